sbc_led_activity: RTL

Generates the 8-bit `fbarSbcLeds` status pattern that the front-panel LED bar multiplexer shows when both selector switches are down. Short single-cycle SBC bus and peripheral events are stretched into human-visible flashes, and a heartbeat blinker shows that the clock and CPU are alive. Outputs are active-high (1 = LED lit). The downstream multiplexer performs the inversion for the common-anode LEDs.

---
 rtl/sbc_led_pkg.sv | 34 +++
 rtl/led_stretch_cell.sv | 37 +++
 rtl/sbc_led_activity.sv | 92 +++++++++
 3 files changed

// File: rtl/sbc_led_pkg.sv
// sbc_led_pkg: LED bit positions and default timing constants for the SBC
// activity LED bar. Other front-panel blocks share these definitions.
package sbc_led_pkg;

  // Bit positions of the activity strobes and the heartbeat in the LED bar
  localparam int LED_RAM  = 0;
  localparam int LED_ROM  = 1;
  localparam int LED_IORD = 2;
  localparam int LED_IOWR = 3;
  localparam int LED_SD   = 4;
  localparam int LED_TX   = 5;
  localparam int LED_RX   = 6;
  localparam int LED_HB   = 7;

  // Number of stretched activity channels (everything below the heartbeat)
  localparam int NUM_EVT = 7;

  // Default timing: 1 ms tick at 25 MHz, 50 ms flash, 1 Hz heartbeat
  localparam int DEFAULT_TICK_DIV      = 25000;
  localparam int DEFAULT_STRETCH_TICKS = 50;
  localparam int DEFAULT_HB_TICKS      = 500;

  // Heartbeat wrap limit: full half-period normally, a quarter of it while
  // the CPU is halted so the fast blink stands out
  function automatic logic [11:0] hbLimitFor(input logic halted, input int hbTicks);
    logic [11:0] limit;
    limit = 12'(hbTicks - 1);
    if (halted) begin
      limit = 12'(hbTicks / 4 - 1);
    end
    return limit;
  endfunction

endpackage

// File: rtl/led_stretch_cell.sv
// led_stretch_cell: turns one activity strobe into a visible flash. Any event
// cycle relights the LED and restarts the hold time; the LED clears on the
// tick that would take the hold counter from 1 to 0.
module led_stretch_cell
  import sbc_led_pkg::*;
#(
  parameter int STRETCH_TICKS = DEFAULT_STRETCH_TICKS
) (
  input  logic pll0_25MHz,
  input  logic reset,
  input  logic evt,
  input  logic tick,
  output logic led
);

  localparam logic [7:0] RELOAD = 8'(STRETCH_TICKS);

  logic [7:0] cnt;

  // Reload on any event (even on a tick, so a late retrigger never drops the
  // LED); otherwise count down one step per tick and clear on the last step
  always_ff @(posedge pll0_25MHz) begin
    if (reset) begin
      cnt <= '0;
      led <= 1'b0;
    end else if (evt) begin
      cnt <= RELOAD;
      led <= 1'b1;
    end else if (tick && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
      if (cnt == 8'd1) begin
        led <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sbc_led_activity.sv
// sbc_led_activity: builds the SBC status byte for the front-panel LED bar.
// Bits 6:0 are stretched bus/peripheral activity, bit 7 a heartbeat that
// blinks fast while the CPU is halted. All outputs come straight from flops.
module sbc_led_activity
  import sbc_led_pkg::*;
#(
  parameter int TICK_DIV      = DEFAULT_TICK_DIV,
  parameter int STRETCH_TICKS = DEFAULT_STRETCH_TICKS,
  parameter int HB_TICKS      = DEFAULT_HB_TICKS
) (
  input  logic               pll0_25MHz,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               cpuHalt,
  output logic [7:0]         fbarSbcLeds
);

  localparam int                 PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [NUM_EVT-1:0] evtQ;
  logic               haltQ;
  logic [PRESC_W-1:0] prescCnt;
  logic               tick;
  logic [11:0]        hbCnt;
  logic [11:0]        hbLimit;
  logic               hb;
  logic [NUM_EVT-1:0] ledVec;

  // Register the strobes and the halt flag once; every cycle evtQ is high
  // counts as an event, there is no edge detection
  always_ff @(posedge pll0_25MHz) begin
    if (reset) begin
      evtQ  <= '0;
      haltQ <= 1'b0;
    end else begin
      evtQ  <= evt;
      haltQ <= cpuHalt;
    end
  end

  // Free-running prescaler; the cycle it sits at its last value is the tick
  always_ff @(posedge pll0_25MHz) begin
    if (reset) begin
      prescCnt <= '0;
    end else if (prescCnt == PRESC_LAST) begin
      prescCnt <= '0;
    end else begin
      prescCnt <= prescCnt + PRESC_W'(1);
    end
  end

  assign tick = (prescCnt == PRESC_LAST);

  // Pick the heartbeat wrap limit from the registered halt state
  always_comb begin
    hbLimit = hbLimitFor(haltQ, HB_TICKS);
  end

  // Heartbeat: count ticks and toggle at the limit; using >= means a sudden
  // drop of the limit (halt raised late in a half-period) wraps on the next tick
  always_ff @(posedge pll0_25MHz) begin
    if (reset) begin
      hbCnt <= '0;
      hb    <= 1'b0;
    end else if (tick) begin
      if (hbCnt >= hbLimit) begin
        hbCnt <= '0;
        hb    <= ~hb;
      end else begin
        hbCnt <= hbCnt + 12'd1;
      end
    end
  end

  // One stretch cell per activity strobe, all sharing the prescaler tick
  for (genvar i = 0; i < NUM_EVT; i++) begin : gCell
    led_stretch_cell #(
      .STRETCH_TICKS(STRETCH_TICKS)
    ) uCell (
      .pll0_25MHz(pll0_25MHz),
      .reset     (reset),
      .evt       (evtQ[i]),
      .tick      (tick),
      .led       (ledVec[i])
    );
  end

  assign fbarSbcLeds[LED_HB]          = hb;
  assign fbarSbcLeds[LED_RX:LED_RAM]  = ledVec;

endmodule
